// File: rtl/clock_tick_pkg.sv
// Shared constants, channel FSM encoding and channel-index width helper for clock_tick_gen.
// No logic; no latency or backpressure of its own.
package clock_tick_pkg;

  localparam int CNT_WIDTH_DEF   = 32;
  localparam int DEFAULT_DIV_DEF = 200_000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // A single channel still needs a one-bit select so the port never collapses to zero width.
  function automatic int ch_idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_tick_channel.sv
// One divider channel: counter, active divisor and a single pending-divisor slot; outputs registered (1 cycle).
// Backpressure: pend_vld high means the slot is full and the parent must hold further writes.
module clock_tick_channel
  import clock_tick_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 wr_vld,
  input  logic [CNT_WIDTH-1:0] wr_dat,
  output logic                 pend_vld,
  output logic                 out_clk,
  output logic                 out_tick
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  ch_state_e            state_q;
  ch_state_e            state_nxt;
  logic [CNT_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] div_nxt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH-1:0] pend_q;
  logic [CNT_WIDTH-1:0] pend_nxt;
  logic                 pend_vld_q;
  logic                 pend_vld_nxt;
  logic [CNT_WIDTH-1:0] half_nxt;
  logic                 live_nxt;
  logic                 out_clk_nxt;
  logic                 out_tick_nxt;
  logic                 div_ok;
  logic                 wrap;

  assign div_ok   = (div_q > ONE);
  assign pend_vld = pend_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_RST;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_clk    <= 1'b0;
      out_tick   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      div_q      <= div_nxt;
      cnt_q      <= cnt_nxt;
      pend_q     <= pend_nxt;
      pend_vld_q <= pend_vld_nxt;
      out_clk    <= out_clk_nxt;
      out_tick   <= out_tick_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    div_nxt      = div_q;
    cnt_nxt      = cnt_q;
    pend_nxt     = pend_q;
    pend_vld_nxt = pend_vld_q;
    wrap         = 1'b0;

    if (!en) begin
      // Stopped: a held divisor lands now; otherwise writes go straight to the active divisor.
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      if (pend_vld_q) begin
        div_nxt      = pend_q;
        pend_vld_nxt = 1'b0;
      end else if (wr_vld) begin
        div_nxt = wr_dat;
      end
    end else if (state_q == ST_IDLE) begin
      // First enabled edge holds cnt at 0 so the opening period is a full D cycles.
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      if (wr_vld) begin
        pend_nxt     = wr_dat;
        pend_vld_nxt = 1'b1;
      end
    end else begin
      // A degenerate divisor wraps every cycle so a retune out of it is never stuck.
      wrap    = !div_ok || (cnt_q == div_q - ONE);
      cnt_nxt = wrap ? '0 : cnt_q + ONE;
      if (wrap && pend_vld_q) begin
        div_nxt      = pend_q;
        pend_vld_nxt = 1'b0;
      end
      // Only reachable with the slot empty, so a write in the wrap cycle waits for the next wrap.
      if (wr_vld) begin
        pend_nxt     = wr_dat;
        pend_vld_nxt = 1'b1;
      end
    end

    half_nxt     = div_nxt - (div_nxt >> 1);
    live_nxt     = (state_nxt == ST_RUN) && (div_nxt > ONE);
    out_clk_nxt  = live_nxt && (cnt_nxt >= half_nxt);
    out_tick_nxt = live_nxt && (cnt_nxt == div_nxt - ONE);
  end

endmodule

// File: rtl/clock_tick_gen.sv
// Multi-channel clock divider with glitch-free runtime retune; outputs registered (1 cycle).
// Backpressure: cfg_ready drops while the addressed channel already holds a pending divisor.
module clock_tick_gen
  import clock_tick_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CHANNELS-1:0]               en,
  input  logic                              cfg_valid,
  input  logic [ch_idx_width(CHANNELS)-1:0] cfg_ch,
  input  logic [CNT_WIDTH-1:0]              cfg_div,
  output logic                              cfg_ready,
  output logic [CHANNELS-1:0]               out_clk,
  output logic [CHANNELS-1:0]               out_tick
);

  localparam int CH_W = ch_idx_width(CHANNELS);

  logic [CHANNELS-1:0] pend_vld;
  logic [CHANNELS-1:0] wr_vld;

  // Unmatched channel indices leave cfg_ready high and no strobe, so such writes vanish.
  always_comb begin
    cfg_ready = 1'b1;
    wr_vld    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend_vld[i];
        wr_vld[i] = cfg_valid & ~pend_vld[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_tick_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .wr_vld   (wr_vld[g]),
      .wr_dat   (cfg_div),
      .pend_vld (pend_vld[g]),
      .out_clk  (out_clk[g]),
      .out_tick (out_tick[g])
    );
  end

endmodule

// File: tb/tb_clock_tick_gen.sv
// Directed bench for clock_tick_gen with a short default divisor so every period is observable.
// Per-cycle traces use '0' low, '1' high, 'T' high with tick, 't' tick while low.
module tb_clock_tick_gen;

  localparam int DEF_DIV = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic [2:0]  out_clk;
  logic [2:0]  out_tick;

  int    total = 0;
  int    bad   = 0;
  string rec0;
  string rec1;

  clock_tick_gen #(
    .CHANNELS    (3),
    .CNT_WIDTH   (32),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .out_clk   (out_clk),
    .out_tick  (out_tick)
  );

  always #5 clk = ~clk;

  function automatic string enc(input int ch);
    if (out_tick[ch]) return out_clk[ch] ? "T" : "t";
    return out_clk[ch] ? "1" : "0";
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rec0 = {rec0, enc(0)};
    rec1 = {rec1, enc(1)};
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 3'b000; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_clk !== 3'b000) begin bad++; $display("FAIL reset_out_clk: got %b want 000", out_clk); end
    total++; if (out_tick !== 3'b000) begin bad++; $display("FAIL reset_out_tick: got %b want 000", out_tick); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_ch0: got %b want 1", cfg_ready); end
    cfg_ch = 2'd1;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_ch1: got %b want 1", cfg_ready); end
  endtask

  // Release mid-cycle, default period on both channels, with an out-of-range write that must vanish.
  task automatic test_default_period();
    en = 3'b011;
    #2;
    reset = 1'b0;
    rec0 = ""; rec1 = "";
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd2;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL oor_ready: got %b want 1", cfg_ready); end
    step(); step();
    cfg_valid = 1'b0; cfg_ch = 2'd0;
    repeat (22) step();
    total++; if (rec0 != "00000011111T00000011111T") begin bad++; $display("FAIL default_ch0: got %s want 00000011111T00000011111T", rec0); end
    total++; if (rec1 != "00000011111T00000011111T") begin bad++; $display("FAIL default_ch1: got %s want 00000011111T00000011111T", rec1); end
  endtask

  // ch0 D=4 then retune to 6 at cnt=1; ch1 keeps running at the default divisor.
  task automatic test_retune();
    rec0 = ""; rec1 = "";
    en = 3'b010;
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd4;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL retune_idle_ready: got %b want 1", cfg_ready); end
    step();
    cfg_valid = 1'b0; en = 3'b011;
    step(); step();
    cfg_valid = 1'b1; cfg_div = 32'd6;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL retune_pending_ready: got %b want 0", cfg_ready); end
    repeat (13) step();
    total++; if (rec0 != "00001T00011T00011T") begin bad++; $display("FAIL retune_ch0: got %s want 00001T00011T00011T", rec0); end
    total++; if (rec1 != "00000011111T000000") begin bad++; $display("FAIL retune_ch1_undisturbed: got %s want 00000011111T000000", rec1); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL retune_slot_freed: got %b want 1", cfg_ready); end
  endtask

  // Write D=5 presented in ch0's wrap cycle: one more period of 6, then periods of 5.
  task automatic test_wrap_write_odd();
    rec0 = ""; rec1 = "";
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd5;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL wrapwrite_held: got %b want 0", cfg_ready); end
    repeat (15) step();
    total++; if (rec0 != "00011T0001T0001T") begin bad++; $display("FAIL odd_div_ch0: got %s want 00011T0001T0001T", rec0); end
    total++; if (rec1 != "11111T0000001111") begin bad++; $display("FAIL odd_div_ch1: got %s want 11111T0000001111", rec1); end
  endtask

  task automatic test_back_to_back();
    int waits;
    rec0 = ""; rec1 = "";
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd4;
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready: got %b want 1", cfg_ready); end
    step();
    cfg_div = 32'd6;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_blocked: got %b want 0", cfg_ready); end
    waits = 0;
    while (cfg_ready !== 1'b1 && waits < 20) begin
      step();
      waits++;
    end
    total++; if (waits != 2) begin bad++; $display("FAIL b2b_wait_cycles: got %0d want 2", waits); end
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_pending: got %b want 0", cfg_ready); end
    repeat (8) step();
    total++; if (rec1 != "1T001T00011T") begin bad++; $display("FAIL b2b_ch1: got %s want 1T001T00011T", rec1); end
    total++; if (rec0 != "0001T0001T00") begin bad++; $display("FAIL b2b_ch0_undisturbed: got %s want 0001T0001T00", rec0); end
  endtask

  // ch0 D=8, pending 10, en dropped at cnt=2 then re-raised.
  task automatic test_en_drop();
    en = 3'b010; cfg_ch = 2'd0;
    step();
    cfg_valid = 1'b1; cfg_div = 32'd8;
    step();
    cfg_valid = 1'b0; en = 3'b011;
    rec0 = "";
    step();
    cfg_valid = 1'b1; cfg_div = 32'd10;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL endrop_pending: got %b want 0", cfg_ready); end
    step();
    en = 3'b010;
    step();
    total++; if (out_clk[0] !== 1'b0 || out_tick[0] !== 1'b0) begin bad++; $display("FAIL endrop_outputs_low: got clk=%b tick=%b want 0 0", out_clk[0], out_tick[0]); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL endrop_pending_applied: got %b want 1", cfg_ready); end
    en = 3'b011;
    repeat (12) step();
    total++; if (rec0 != "0000000001111T00") begin bad++; $display("FAIL endrop_ch0: got %s want 0000000001111T00", rec0); end
  endtask

  task automatic test_async_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd3;
    step();
    cfg_valid = 1'b0;
    repeat (4) step();
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL areset_pre_pending: got %b want 0", cfg_ready); end
    total++; if (out_clk[0] !== 1'b1) begin bad++; $display("FAIL areset_pre_high: got %b want 1", out_clk[0]); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (out_clk !== 3'b000 || out_tick !== 3'b000) begin bad++; $display("FAIL areset_immediate: got clk=%b tick=%b want 000 000", out_clk, out_tick); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL areset_pending_cleared: got %b want 1", cfg_ready); end
    #1;
    reset = 1'b0;
    rec0 = ""; rec1 = "";
    repeat (24) step();
    total++; if (rec0 != "00000011111T00000011111T") begin bad++; $display("FAIL areset_period_ch0: got %s want 00000011111T00000011111T", rec0); end
    total++; if (rec1 != "00000011111T00000011111T") begin bad++; $display("FAIL areset_period_ch1: got %s want 00000011111T00000011111T", rec1); end
    // D=1 written in ch0's wrap cycle lands one period later, then the channel goes silent.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd1;
    rec0 = ""; rec1 = "";
    step();
    cfg_valid = 1'b0;
    repeat (19) step();
    total++; if (rec0 != "00000011111T00000000") begin bad++; $display("FAIL div1_silent_ch0: got %s want 00000011111T00000000", rec0); end
    total++; if (rec1 != "00000011111T00000011") begin bad++; $display("FAIL div1_ch1: got %s want 00000011111T00000011", rec1); end
  endtask

  task automatic test_div_zero();
    en = 3'b001;
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd0;
    step();
    cfg_valid = 1'b0; en = 3'b011;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL div0_direct_ready: got %b want 1", cfg_ready); end
    rec0 = ""; rec1 = "";
    repeat (6) step();
    total++; if (rec1 != "000000") begin bad++; $display("FAIL div0_silent_ch1: got %s want 000000", rec1); end
    total++; if (rec0 != "000000") begin bad++; $display("FAIL div0_ch0_still_silent: got %s want 000000", rec0); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_retune();
    test_wrap_write_odd();
    test_back_to_back();
    test_en_drop();
    test_async_reset();
    test_div_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
